// File: rtl/uart_pkg.sv
// Shared FSM encoding and default sizing for the buffered UART transmitter.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 868;
    localparam int DEFAULT_DEPTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; flush overrides push and pop.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered 8N1 UART transmitter: bus writes queue bytes, the FSM serialises them back to back.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low)
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (high); may chain straight into the next start bit
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_we,
    input  logic                     uart_clear,
    input  logic [7:0]               uart_data_in,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  rd_data;
    logic        baud_tc;
    logic        flush;
    logic        push;
    logic        pop;

    assign flush   = uart_we && uart_clear;
    assign push    = uart_we && !uart_clear;
    assign baud_tc = (baud_cnt == '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (uart_data_in),
        .rd_data (rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A flush on the same edge suppresses the pop, so no new frame starts.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_tx    = 1'b1;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                busy    = 1'b1;
                uart_tx = 1'b0;
                if (baud_tc) state_next = ST_DATA;
            end
            ST_DATA: begin
                busy    = 1'b1;
                uart_tx = shift[0];
                if (baud_tc && bit_cnt == 3'd7) state_next = ST_STOP;
            end
            ST_STOP: begin
                busy = 1'b1;
                if (baud_tc) begin
                    if (!fifo_empty && !flush) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (pop) begin
            shift    <= rd_data;
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
        end else if (state != ST_IDLE) begin
            if (!baud_tc) begin
                baud_cnt <= baud_cnt - 16'd1;
            end else if (state_next == ST_IDLE) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= BAUD_LAST;
                if (state == ST_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    // Sticky until a flush or reset; a write dropped against a full FIFO sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                overflow <= 1'b0;
        else if (flush)                         overflow <= 1'b0;
        else if (push && fifo_full && !pop)     overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: frame-timer reference model plus directed literal checks.
module tb_uart_tx_buffer;

    localparam int BD = 4;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_we = 1'b0;
    logic       uart_clear = 1'b0;
    logic [7:0] uart_data_in = 8'h00;
    logic       uart_tx;
    logic       busy;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    uart_tx_buffer #(
        .BAUD_DIV (BD),
        .DEPTH    (DP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_we      (uart_we),
        .uart_clear   (uart_clear),
        .uart_data_in (uart_data_in),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of bytes and a frame timer counting cycles since the start bit began.
    logic [7:0] q[$];
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit fl;
        bit pu;
        if (rst) begin
            q.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
        end else begin
            fl = uart_we && uart_clear;
            pu = uart_we && !uart_clear;
            if (m_act) begin
                m_t++;
                if (m_t == 10 * BD) m_act = 1'b0;
            end
            if (!m_act && q.size() > 0 && !fl) begin
                m_byte = q.pop_front();
                m_act  = 1'b1;
                m_t    = 0;
            end
            if (fl) begin
                q.delete();
                m_ovf = 1'b0;
            end
            if (pu) begin
                if (q.size() < DP) q.push_back(uart_data_in);
                else               m_ovf = 1'b1;
            end
        end
    end

    function automatic int exp_tx();
        int k;
        if (!m_act) return 1;
        k = m_t / BD;
        if (k == 0) return 0;
        if (k <= 8) return int'(m_byte[k-1]);
        return 1;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_uart_tx",    int'(uart_tx),    exp_tx());
            chk("model_busy",       int'(busy),       int'(m_act));
            chk("model_fifo_count", int'(fifo_count), q.size());
            chk("model_fifo_empty", int'(fifo_empty), int'(q.size() == 0));
            chk("model_fifo_full",  int'(fifo_full),  int'(q.size() == DP));
            chk("model_overflow",   int'(overflow),   int'(m_ovf));
        end
    end

    task automatic write(input logic [7:0] d, input logic clr);
        uart_we      = 1'b1;
        uart_clear   = clr;
        uart_data_in = d;
        @(negedge clk);
        uart_we    = 1'b0;
        uart_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        idle(2);
        chk("rst_uart_tx",    int'(uart_tx),    1);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_fifo_empty", int'(fifo_empty), 1);
        chk("rst_fifo_full",  int'(fifo_full),  0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_overflow",   int'(overflow),   0);
        rst = 1'b0;
        idle(1);
    endtask

    int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int samp[60];
    int nb;
    int falls;
    bit prev_busy;

    initial begin
        do_reset();
        cmp_on = 1'b1;

        // 0xA5 from idle
        write(8'hA5, 1'b0);
        chk("a5_count_after_e0", int'(fifo_count), 1);
        chk("a5_tx_after_e0",    int'(uart_tx),    1);
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            samp[i] = int'(uart_tx);
            nb += int'(busy);
        end
        chk("a5_start_bit", samp[0], 0);
        chk("a5_start_mid", samp[2], 0);
        for (int b = 0; b < 8; b++) chk($sformatf("a5_bit%0d", b), samp[4*(b+1)+2], a5_bits[b]);
        chk("a5_stop_bit",     samp[38], 1);
        chk("a5_idle_after",   samp[45], 1);
        chk("a5_busy_cycles",  nb,       40);

        // three back-to-back frames
        do_reset();
        nb = 0;
        falls = 0;
        prev_busy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            write(8'(k), 1'b0);
            nb += int'(busy);
            if (prev_busy && !busy) falls++;
            prev_busy = busy;
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            nb += int'(busy);
            if (prev_busy && !busy) falls++;
            prev_busy = busy;
        end
        chk("b2b_busy_cycles", nb,                120);
        chk("b2b_busy_gaps",   falls,             1);
        chk("b2b_empty_end",   int'(fifo_empty),  1);

        // six writes from idle: one popped, four held, sixth dropped
        do_reset();
        for (int k = 0; k < 6; k++) write(8'h10 + 8'(k), 1'b0);
        chk("ovf_flag",  int'(overflow),   1);
        chk("ovf_count", int'(fifo_count), 4);
        chk("ovf_full",  int'(fifo_full),  1);
        write(8'h00, 1'b1);
        chk("ovf_flush_clears", int'(overflow),   0);
        chk("ovf_flush_count",  int'(fifo_count), 0);
        chk("ovf_flush_busy",   int'(busy),       1);
        idle(50);

        // push against a full FIFO on the same edge as the end-of-stop pop
        do_reset();
        for (int k = 0; k < 5; k++) write(8'h20 + 8'(k), 1'b0);
        chk("fullpop_count_pre", int'(fifo_count), 4);
        chk("fullpop_ovf_pre",   int'(overflow),   0);
        idle(36);
        chk("fullpop_count_e40", int'(fifo_count), 4);
        write(8'h77, 1'b0);
        chk("fullpop_count", int'(fifo_count), 4);
        chk("fullpop_ovf",   int'(overflow),   0);
        chk("fullpop_busy",  int'(busy),       1);
        chk("fullpop_tx",    int'(uart_tx),    0);
        idle(200);

        // flush during DATA of 0x55 with two bytes queued
        do_reset();
        write(8'h55, 1'b0);
        write(8'hAA, 1'b0);
        write(8'hCC, 1'b0);
        chk("flush_count_pre", int'(fifo_count), 2);
        idle(12);
        write(8'h00, 1'b1);
        chk("flush_count",    int'(fifo_count), 0);
        chk("flush_busy_mid", int'(busy),       1);
        idle(30);
        chk("flush_idle_busy", int'(busy),       0);
        chk("flush_idle_tx",   int'(uart_tx),    1);
        chk("flush_ovf",       int'(overflow),   0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            nb += int'(busy);
        end
        chk("flush_stays_idle", nb, 0);

        // reset at cycle 10 of a frame
        do_reset();
        write(8'h3C, 1'b0);
        idle(10);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_tx",    int'(uart_tx),    1);
        chk("rstmid_busy",  int'(busy),       0);
        chk("rstmid_count", int'(fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nb += int'(busy);
        end
        chk("rstmid_no_tx", nb, 0);
        write(8'h81, 1'b0);
        idle(1);
        chk("rstmid_new_push_starts", int'(busy), 1);
        idle(45);

        // randomized traffic in phases of differing write intensity
        for (int p = 0; p < 20; p++) begin
            int rate;
            case (p % 3)
                0:       rate = 2;
                1:       rate = 10;
                default: rate = 45;
            endcase
            for (int i = 0; i < 200; i++) begin
                uart_we      = ($urandom_range(0, 99) < rate);
                uart_clear   = uart_we && ($urandom_range(0, 24) == 0);
                uart_data_in = 8'($urandom);
                @(negedge clk);
            end
        end
        uart_we    = 1'b0;
        uart_clear = 1'b0;
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
